// File: rtl/decoder_nto2n_reg.sv
// Registered N-to-2^N one-hot decoder with a free-running scan mode.
// Decode transfers use a valid/ready handshake; scan steps one bit every SCAN_DIV cycles.
module decoder_nto2n_reg #(
    parameter int N          = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [N-1:0]       in,
    output logic               in_ready,
    output logic [(1<<N)-1:0]  y,
    output logic               y_valid
);

    localparam int W  = 1 << N;
    localparam int DW = (SCAN_DIV <= 1) ? 1 : $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  onehot_q, onehot_d;
    logic [DW-1:0] div_q, div_d;
    logic          valid_d;
    logic          accept;

    assign in_ready = en & ~mode;
    assign accept   = in_valid & in_ready;
    assign y        = ACTIVE_LOW ? ~onehot_q : onehot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            div_q    <= '0;
            y_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            div_q    <= div_d;
            y_valid  <= valid_d;
        end
    end

    // Priority: en=0 clears everything, then mode=1 (scan), then a decode transfer.
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        div_d    = div_q;
        valid_d  = y_valid;
        if (!en) begin
            state_d  = IDLE;
            onehot_d = '0;
            div_d    = '0;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DECODE: begin
                    if (mode) begin
                        state_d  = SCAN;
                        onehot_d = W'(1);
                        div_d    = '0;
                        valid_d  = 1'b1;
                    end else if (accept) begin
                        state_d  = DECODE;
                        onehot_d = W'(1) << in;
                        valid_d  = 1'b1;
                    end
                end
                SCAN: begin
                    if (mode) begin
                        if (div_q == DIV_LAST) begin
                            onehot_d = {onehot_q[W-2:0], onehot_q[W-1]};
                            div_d    = '0;
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end else if (accept) begin
                        state_d  = DECODE;
                        onehot_d = W'(1) << in;
                        div_d    = '0;
                        valid_d  = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                        div_d    = '0;
                        valid_d  = 1'b0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    onehot_d = '0;
                    div_d    = '0;
                    valid_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Directed bench: default decoder plus an ACTIVE_LOW=1, SCAN_DIV=1 instance on shared inputs.
module tb_decoder_nto2n_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] in;
    logic       in_ready, in_ready_al;
    logic [7:0] y, y_al;
    logic       y_valid, y_valid_al;

    int unsigned errors = 0;
    int unsigned checks = 0;

    decoder_nto2n_reg #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in(in), .in_ready(in_ready), .y(y), .y_valid(y_valid)
    );

    decoder_nto2n_reg #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in(in), .in_ready(in_ready_al), .y(y_al), .y_valid(y_valid_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_y, exp_al;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in = 3'd0;
        #3;
        check("rst_y", y, 8'h00);
        check("rst_yv", y_valid, 1'b0);
        check("rst_y_al", y_al, 8'hff);
        check("rst_yv_al", y_valid_al, 1'b0);
        step(); step();
        rst_n = 1'b1;

        // Back-to-back decode
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; in = 3'd1;
        #1 check("rdy_decode", in_ready, 1'b1);
        step(); check("dec1", y, 8'h02); check("dec1_v", y_valid, 1'b1);
        check("dec1_al", y_al, 8'hfd);
        in = 3'd3; step(); check("dec3", y, 8'h08); check("dec3_v", y_valid, 1'b1);
        in = 3'd2; step(); check("dec2", y, 8'h04);
        in = 3'd0; step(); check("dec0", y, 8'h01); check("dec0_al", y_al, 8'hfe);
        in_valid = 1'b0; in = 3'd6; step();
        check("hold_y", y, 8'h01); check("hold_v", y_valid, 1'b1);
        in_valid = 1'b1; in = 3'd7; step(); check("dec7", y, 8'h80);

        // en=0 clears and blocks transfers
        en = 1'b0; in = 3'd4;
        #1 check("rdy_en0", in_ready, 1'b0);
        step(); check("en0_y", y, 8'h00); check("en0_v", y_valid, 1'b0);
        check("en0_y_al", y_al, 8'hff);
        step(); check("en0_hold", y, 8'h00);

        // Scan with in_valid ignored
        en = 1'b1; mode = 1'b1; in_valid = 1'b1; in = 3'd5;
        for (int k = 0; k < 36; k++) begin
            step();
            exp_y  = 8'h01 << ((k / 4) % 8);
            exp_al = ~(8'h01 << (k % 8));
            check($sformatf("scan%0d", k), y, exp_y);
            check($sformatf("scan_al%0d", k), y_al, exp_al);
            check($sformatf("scan_rdy%0d", k), in_ready, 1'b0);
        end
        check("scan_v", y_valid, 1'b1);

        // Leave scan with a transfer, then without one
        mode = 1'b0; in_valid = 1'b1; in = 3'd5;
        step(); check("scan2dec", y, 8'h20); check("scan2dec_v", y_valid, 1'b1);
        mode = 1'b1; step(); check("dec2scan", y, 8'h01);
        mode = 1'b0; in_valid = 1'b0; step();
        check("scan2idle", y, 8'h00); check("scan2idle_v", y_valid, 1'b0);

        // Asynchronous reset mid-scan
        mode = 1'b1;
        repeat (6) step();
        check("prerst", y, 8'h02);
        #2 rst_n = 1'b0;
        #1 check("arst_y", y, 8'h00); check("arst_v", y_valid, 1'b0);
        check("arst_y_al", y_al, 8'hff);
        step(); rst_n = 1'b1;
        step(); check("rescan", y, 8'h01); check("rescan_v", y_valid, 1'b1);
        repeat (4) step();
        check("rescan_adv", y, 8'h02);
        mode = 1'b0; in_valid = 1'b1; in = 3'd6;
        step(); check("post_rst_dec", y, 8'h40); check("post_rst_al", y_al, 8'hbf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
